// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-clock-domain half of an async FIFO.
// Holds the binary and Gray write pointers, drives the RAM write port and
// produces registered full, almost-full, fill level and sticky overflow.
// Optional feature macro: FIFO_WR_OVF_CNT_EN builds a 16-bit saturating
// dropped-write counter on w_ovf_cnt_o. Without it w_ovf_cnt_o is tied to 0.
//
// Handshake: w_inc_i is a write request and w_en_o is its acceptance. A write
// happens on a rising edge where w_inc_i=1 and w_full_o=0, which is exactly
// when w_en_o=1. A request while full is dropped and flagged as overflow.
module fifo_write_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int PTR_WIDTH    = 4,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  w_clk_i,
  input  logic                  w_rst_i,
  input  logic                  w_inc_i,
  input  logic                  w_ovf_clr_i,
  input  logic [PTR_WIDTH-1:0]  w_r_ptr_i,
  output logic [PTR_WIDTH-1:0]  w_ptr_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic                  w_en_o,
  output logic                  w_full_o,
  output logic                  w_afull_o,
  output logic [PTR_WIDTH-1:0]  w_level_o,
  output logic                  w_ovf_o,
  output logic [15:0]           w_ovf_cnt_o
);

  // One extra bit so a threshold equal to the depth still fits.
  localparam logic [PTR_WIDTH:0] AFULL_TH = AFULL_THRESH[PTR_WIDTH:0];

  logic [PTR_WIDTH-1:0] bin_q, bin_d;
  logic [PTR_WIDTH-1:0] gray_q, gray_d;
  logic [PTR_WIDTH-1:0] level_q, level_d;
  logic [PTR_WIDTH-1:0] rbin;
  logic                 full_q, full_d;
  logic                 afull_q, afull_d;
  logic                 ovf_q, ovf_d;
  logic                 accept;
  logic                 drop;

  assign accept = w_inc_i & ~full_q;
  assign drop   = w_inc_i & full_q;

  // Gray-to-binary of the synchronized read pointer: each bit is the XOR of
  // itself and every more significant Gray bit.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      rbin[i] = ^(w_r_ptr_i >> i);
    end
  end

  // Next pointers, flags and level, all derived from the post-write pointer so
  // full takes effect on the very edge that fills the FIFO.
  always_comb begin
    bin_d   = bin_q + {{(PTR_WIDTH-1){1'b0}}, accept};
    gray_d  = bin_d ^ (bin_d >> 1);
    full_d  = (gray_d == {~w_r_ptr_i[PTR_WIDTH-1 -: 2], w_r_ptr_i[PTR_WIDTH-3:0]});
    level_d = bin_d - rbin;
    afull_d = ({1'b0, level_d} >= AFULL_TH);
    ovf_d   = drop | (ovf_q & ~w_ovf_clr_i);
  end

  // Pointer, status and sticky overflow registers.
  always_ff @(posedge w_clk_i) begin
    if (!w_rst_i) begin
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIFO_WR_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Dropped-write counter: a drop outranks a clear, so clear+drop loads 1.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      if (w_ovf_clr_i) begin
        ovf_cnt_d = 16'd1;
      end else if (ovf_cnt_q != 16'hFFFF) begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
    end else if (w_ovf_clr_i) begin
      ovf_cnt_d = 16'd0;
    end
  end

  // Counter register.
  always_ff @(posedge w_clk_i) begin
    if (!w_rst_i) begin
      ovf_cnt_q <= 16'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign w_ovf_cnt_o = ovf_cnt_q;
`else
  assign w_ovf_cnt_o = 16'h0000;
`endif

  assign w_en_o    = accept;
  assign w_addr_o  = bin_q[ADDR_WIDTH-1:0];
  assign w_ptr_o   = gray_q;
  assign w_full_o  = full_q;
  assign w_afull_o = afull_q;
  assign w_level_o = level_q;
  assign w_ovf_o   = ovf_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Bench for fifo_write_ctrl (ADDR_WIDTH=3, PTR_WIDTH=4, AFULL_THRESH=6).
// The reference model counts accepted writes and reads as plain integers;
// level is their difference and full means eight entries held.
module tb_fifo_write_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        w_rst_i = 1'b0;
  logic        w_inc_i = 1'b0;
  logic        w_ovf_clr_i = 1'b0;
  logic [3:0]  w_r_ptr_i = 4'd0;
  logic [3:0]  w_ptr_o;
  logic [2:0]  w_addr_o;
  logic        w_en_o;
  logic        w_full_o;
  logic        w_afull_o;
  logic [3:0]  w_level_o;
  logic        w_ovf_o;
  logic [15:0] w_ovf_cnt_o;

  fifo_write_ctrl #(.ADDR_WIDTH(3), .PTR_WIDTH(4), .AFULL_THRESH(6)) dut (
    .w_clk_i     (clk),
    .w_rst_i     (w_rst_i),
    .w_inc_i     (w_inc_i),
    .w_ovf_clr_i (w_ovf_clr_i),
    .w_r_ptr_i   (w_r_ptr_i),
    .w_ptr_o     (w_ptr_o),
    .w_addr_o    (w_addr_o),
    .w_en_o      (w_en_o),
    .w_full_o    (w_full_o),
    .w_afull_o   (w_afull_o),
    .w_level_o   (w_level_o),
    .w_ovf_o     (w_ovf_o),
    .w_ovf_cnt_o (w_ovf_cnt_o)
  );

  // ---------------- scoreboard storage ----------------
  typedef struct packed {
    logic        chk_comb;
    logic        rst;
    logic        en;
    logic [2:0]  addr;
    logic [3:0]  ptr;
    logic        full;
    logic        afull;
    logic [3:0]  level;
    logic        ovf;
    logic [15:0] cnt;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model state ----------------
  int wc = 0;          // total accepted writes since reset
  int rc = 0;          // total reads reflected on the synced read pointer
  bit full_m  = 1'b0;
  bit afull_m = 1'b0;
  bit ovf_m   = 1'b0;
  int lvl_m   = 0;
  int cnt_m   = 0;
  bit model_valid = 1'b0;

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = 4'(n % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit inc, input bit clr, input bit rst_n, input bit rd);
    exp_t e;
    bit   drop;
    @(negedge clk);
    if (!rst_n) rc = 0;
    else if (rd && rc < wc) rc++;
    w_inc_i     = inc;
    w_ovf_clr_i = clr;
    w_rst_i     = rst_n;
    w_r_ptr_i   = to_gray(rc);

    e.chk_comb = model_valid;
    e.rst      = !rst_n;
    e.en       = inc & ~full_m;
    e.addr     = 3'(wc % 8);

    if (!rst_n) begin
      wc = 0; full_m = 0; afull_m = 0; ovf_m = 0; lvl_m = 0; cnt_m = 0;
      model_valid = 1'b1;
    end else begin
      drop = inc & full_m;
      if (inc && !full_m) wc++;
      lvl_m   = wc - rc;
      full_m  = (lvl_m == 8);
      afull_m = (lvl_m >= 6);
      ovf_m   = drop | (ovf_m & ~clr);
`ifdef FIFO_WR_OVF_CNT_EN
      if (drop) cnt_m = clr ? 1 : ((cnt_m < 65535) ? cnt_m + 1 : cnt_m);
      else if (clr) cnt_m = 0;
`else
      cnt_m = 0;
`endif
    end

    e.ptr   = to_gray(wc);
    e.full  = full_m;
    e.afull = afull_m;
    e.level = 4'(lvl_m);
    e.ovf   = ovf_m;
    e.cnt   = 16'(cnt_m);
    exp_q.push_back(EXP_W'(e));
  endtask

  // ---------------- monitor ----------------
  logic       s_en;
  logic [2:0] s_addr;
  logic [3:0] prev_ptr = 4'd0;
  bit         have_prev = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      s_en   = w_en_o;
      s_addr = w_addr_o;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        if (e.chk_comb) begin
          chk("w_en", 32'(s_en), 32'(e.en));
          if (e.en) chk("w_addr", 32'(s_addr), 32'(e.addr));
        end
        chk("w_ptr",     32'(w_ptr_o),     32'(e.ptr));
        chk("w_full",    32'(w_full_o),    32'(e.full));
        chk("w_afull",   32'(w_afull_o),   32'(e.afull));
        chk("w_level",   32'(w_level_o),   32'(e.level));
        chk("w_ovf",     32'(w_ovf_o),     32'(e.ovf));
        chk("w_ovf_cnt", 32'(w_ovf_cnt_o), 32'(e.cnt));
        if (!e.rst && have_prev)
          chk("ptr_one_bit_step", 32'($countones(prev_ptr ^ w_ptr_o) <= 1), 32'd1);
        prev_ptr  = w_ptr_o;
        have_prev = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Fill: eight writes, afull after the sixth, full after the eighth
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
    // Two dropped writes while full
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    // One read frees an entry; next write refills
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    // Clear while a write is dropped: set wins, then clear alone
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    // Steady write/read pairs lagging by two, wrapping the pointers
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 1, 1);
    // Reset in the middle of a burst at level five
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    // Random traffic, alternating read-heavy and write-heavy phases
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 99) != 0,
             (ph % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8));
      end
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
